// File: rtl/sram_xbar_mn_pkg.sv
// +--------------------------------------------------------------------------+
// | sram_xbar_pkg : shared types and width helpers for sram_xbar_mn          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package sram_xbar_pkg;

  // Slave index field is sized for the largest supported slave count.
  localparam int SIDX_W_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [SIDX_W_MAX-1:0] sidx;
    logic                  decerr;
  } rsp_tag_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_xbar_mn_if.sv
// +--------------------------------------------------------------------------+
// | sram_xbar_mn_if : flattened master-side and slave-side SRAM port bundle  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sram_xbar_mn_if #(
  parameter int LEN_ADDR   = 32,
  parameter int LEN_DATA   = 32,
  parameter int NUM_MASTER = 2,
  parameter int NUM_SLAVE  = 4
);
  localparam int BW = LEN_DATA / 8;

  logic [NUM_MASTER-1:0]          m_ena;
  logic [NUM_MASTER*BW-1:0]       m_wea;
  logic [NUM_MASTER*LEN_ADDR-1:0] m_addra;
  logic [NUM_MASTER*LEN_DATA-1:0] m_dina;
  logic [NUM_MASTER-1:0]          m_grant;
  logic [NUM_MASTER-1:0]          m_rvalid;
  logic [NUM_MASTER*LEN_DATA-1:0] m_douta;
  logic [NUM_MASTER-1:0]          m_decerr;

  logic [NUM_SLAVE-1:0]           s_ena;
  logic [NUM_SLAVE*BW-1:0]        s_wea;
  logic [NUM_SLAVE*LEN_ADDR-1:0]  s_addra;
  logic [NUM_SLAVE*LEN_DATA-1:0]  s_dina;
  logic [NUM_SLAVE*LEN_DATA-1:0]  s_douta;

  // Environment view: issues master requests and models the BRAM banks.
  modport master (
    output m_ena, m_wea, m_addra, m_dina,
    input  m_grant, m_rvalid, m_douta, m_decerr,
    input  s_ena, s_wea, s_addra, s_dina,
    output s_douta
  );

  // Crossbar view.
  modport slave (
    input  m_ena, m_wea, m_addra, m_dina,
    output m_grant, m_rvalid, m_douta, m_decerr,
    output s_ena, s_wea, s_addra, s_dina,
    input  s_douta
  );

endinterface

`default_nettype wire

// File: rtl/sram_xbar_mn_rr_arb.sv
// +--------------------------------------------------------------------------+
// | sram_xbar_rr_arb : round-robin arbiter, one-hot grant, rotating pointer  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sram_xbar_rr_arb
  import sram_xbar_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic [NUM_REQ-1:0]            req_i,
  output logic      [NUM_REQ-1:0]            gnt_o,
  output logic      [sel_width(NUM_REQ)-1:0] idx_o,
  output logic                               any_o
);

  localparam int IW = sel_width(NUM_REQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // Scan from the pointer upward, wrapping; first requester wins.
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_o) begin
      ptr_d = (idx_o == IW'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_xbar_mn.sv
// +--------------------------------------------------------------------------+
// | sram_xbar_mn : M-master x N-slave SRAM crossbar, per-slave round-robin    |
// | Optional: SRAM_XBAR_DECERR_EN (decode-error responses for out-of-range)   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sram_xbar_mn
  import sram_xbar_pkg::*;
#(
  parameter int LEN_ADDR   = 32,
  parameter int LEN_DATA   = 32,
  parameter int NUM_MASTER = 2,
  parameter int NUM_SLAVE  = 4,
  parameter int READ_LAT   = 1,
  parameter int SEL_LSB    = 28
) (
  input wire logic      clk,
  input wire logic      rst,
  sram_xbar_mn_if.slave bus_io
);

  localparam int SW = $clog2(NUM_SLAVE);
  localparam int BW = byte_lanes(LEN_DATA);
  localparam int MW = sel_width(NUM_MASTER);

  logic [SW-1:0]         w_sel   [NUM_MASTER];
  logic [SW-1:0]         w_tgt   [NUM_MASTER];
  logic [NUM_MASTER-1:0] w_oor;
  logic [NUM_MASTER-1:0] w_drop;
  logic [NUM_MASTER-1:0] w_read;
  logic [NUM_MASTER-1:0] w_grant;

  logic [NUM_MASTER-1:0] w_req_s  [NUM_SLAVE];
  logic [NUM_MASTER-1:0] w_gnt_s  [NUM_SLAVE];
  logic [MW-1:0]         w_widx_s [NUM_SLAVE];
  logic                  w_any_s  [NUM_SLAVE];

  logic [NUM_SLAVE-1:0]          w_s_ena;
  logic [NUM_SLAVE*BW-1:0]       w_s_wea;
  logic [NUM_SLAVE*LEN_ADDR-1:0] w_s_addra;
  logic [NUM_SLAVE*LEN_DATA-1:0] w_s_dina;

  rsp_tag_t w_tag_in [NUM_MASTER];
  rsp_tag_t w_tag_out[NUM_MASTER];
  rsp_tag_t pipe_q   [NUM_MASTER][READ_LAT];

  logic [NUM_MASTER-1:0]          w_rvalid;
  logic [NUM_MASTER-1:0]          w_decerr;
  logic [NUM_MASTER*LEN_DATA-1:0] w_douta;

  // Address decode; w_drop marks requests that bypass every slave.
  always_comb begin
    for (int m = 0; m < NUM_MASTER; m++) begin
      w_sel[m]  = bus_io.m_addra[m*LEN_ADDR + SEL_LSB +: SW];
      w_oor[m]  = (int'(w_sel[m]) >= NUM_SLAVE);
      w_read[m] = (bus_io.m_wea[m*BW +: BW] == '0);
`ifdef SRAM_XBAR_DECERR_EN
      w_tgt[m]  = w_sel[m];
      w_drop[m] = w_oor[m];
`else
      w_tgt[m]  = w_oor[m] ? SW'(NUM_SLAVE - 1) : w_sel[m];
      w_drop[m] = 1'b0;
`endif
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SLAVE; s++) begin
      for (int m = 0; m < NUM_MASTER; m++) begin
        w_req_s[s][m] = bus_io.m_ena[m] & ~w_drop[m] & (w_tgt[m] == SW'(s));
      end
    end
  end

  generate
    for (genvar s = 0; s < NUM_SLAVE; s++) begin : g_arb
      sram_xbar_rr_arb #(
        .NUM_REQ (NUM_MASTER)
      ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (w_req_s[s]),
        .gnt_o (w_gnt_s[s]),
        .idx_o (w_widx_s[s]),
        .any_o (w_any_s[s])
      );
    end
  endgenerate

  // An idle arbiter reports index 0, so idle slaves see master 0's addr/data.
  always_comb begin
    w_s_ena   = '0;
    w_s_wea   = '0;
    w_s_addra = '0;
    w_s_dina  = '0;
    for (int s = 0; s < NUM_SLAVE; s++) begin
      w_s_ena[s] = w_any_s[s];
      if (w_any_s[s]) begin
        w_s_wea[s*BW +: BW] = bus_io.m_wea[int'(w_widx_s[s])*BW +: BW];
      end
      w_s_addra[s*LEN_ADDR +: LEN_ADDR] = bus_io.m_addra[int'(w_widx_s[s])*LEN_ADDR +: LEN_ADDR];
      w_s_dina[s*LEN_DATA +: LEN_DATA]  = bus_io.m_dina[int'(w_widx_s[s])*LEN_DATA +: LEN_DATA];
    end
  end

  always_comb begin
    w_grant = bus_io.m_ena & w_drop;
    for (int s = 0; s < NUM_SLAVE; s++) begin
      w_grant = w_grant | w_gnt_s[s];
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_MASTER; m++) begin
      w_tag_in[m].valid  = w_grant[m] & w_read[m];
      w_tag_in[m].sidx   = SIDX_W_MAX'(w_tgt[m]);
      w_tag_in[m].decerr = w_grant[m] & w_read[m] & w_drop[m];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < NUM_MASTER; m++) begin
        for (int k = 0; k < READ_LAT; k++) begin
          pipe_q[m][k] <= '0;
        end
      end
    end else begin
      for (int m = 0; m < NUM_MASTER; m++) begin
        pipe_q[m][0] <= w_tag_in[m];
        for (int k = 1; k < READ_LAT; k++) begin
          pipe_q[m][k] <= pipe_q[m][k-1];
        end
      end
    end
  end

  // Read data is steered by the registered tag; nothing returns on decerr.
  always_comb begin
    w_douta = '0;
    for (int m = 0; m < NUM_MASTER; m++) begin
      w_tag_out[m] = pipe_q[m][READ_LAT-1];
      w_rvalid[m]  = w_tag_out[m].valid;
`ifdef SRAM_XBAR_DECERR_EN
      w_decerr[m]  = w_tag_out[m].decerr;
`else
      w_decerr[m]  = 1'b0;
`endif
      if (w_tag_out[m].valid && !w_tag_out[m].decerr) begin
        for (int s = 0; s < NUM_SLAVE; s++) begin
          if (w_tag_out[m].sidx == SIDX_W_MAX'(s)) begin
            w_douta[m*LEN_DATA +: LEN_DATA] = bus_io.s_douta[s*LEN_DATA +: LEN_DATA];
          end
        end
      end
    end
  end

  assign bus_io.m_grant  = w_grant;
  assign bus_io.m_rvalid = w_rvalid;
  assign bus_io.m_decerr = w_decerr;
  assign bus_io.m_douta  = w_douta;
  assign bus_io.s_ena    = w_s_ena;
  assign bus_io.s_wea    = w_s_wea;
  assign bus_io.s_addra  = w_s_addra;
  assign bus_io.s_dina   = w_s_dina;

endmodule

`default_nettype wire

// File: tb/tb_sram_xbar_mn.sv
// +--------------------------------------------------------------------------+
// | tb_sram_xbar_mn : directed bench, 2x4 lat-1 and 2x3 lat-3 crossbars     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sram_xbar_mn;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  sram_xbar_mn_if #(.LEN_ADDR(32), .LEN_DATA(32), .NUM_MASTER(2), .NUM_SLAVE(4)) bus_a ();
  sram_xbar_mn_if #(.LEN_ADDR(32), .LEN_DATA(32), .NUM_MASTER(2), .NUM_SLAVE(3)) bus_b ();

  sram_xbar_mn #(
    .LEN_ADDR(32), .LEN_DATA(32), .NUM_MASTER(2), .NUM_SLAVE(4), .READ_LAT(1), .SEL_LSB(28)
  ) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_a.slave)
  );

  sram_xbar_mn #(
    .LEN_ADDR(32), .LEN_DATA(32), .NUM_MASTER(2), .NUM_SLAVE(3), .READ_LAT(3), .SEL_LSB(28)
  ) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_b.slave)
  );

  // BRAM bank models: word (s, w) initialises to 0x5000_0000 | s<<16 | w.
  logic [31:0] mem_a [4][16];
  logic [31:0] rd_a  [4];
  logic [31:0] mem_b [3][16];
  logic [31:0] rd_b  [3][3];

  function automatic logic [31:0] pat(input int s, input int w);
    return 32'h5000_0000 | (32'(s) << 16) | 32'(w);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        rd_a[s] <= '0;
        for (int w = 0; w < 16; w++) mem_a[s][w] <= pat(s, w);
      end
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < 3; k++) rd_b[s][k] <= '0;
        for (int w = 0; w < 16; w++) mem_b[s][w] <= pat(s, w);
      end
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (bus_a.s_ena[s]) begin
          for (int b = 0; b < 4; b++) begin
            if (bus_a.s_wea[s*4+b])
              mem_a[s][bus_a.s_addra[s*32+2 +: 4]][b*8 +: 8] <= bus_a.s_dina[s*32+b*8 +: 8];
          end
          rd_a[s] <= mem_a[s][bus_a.s_addra[s*32+2 +: 4]];
        end
      end
      for (int s = 0; s < 3; s++) begin
        rd_b[s][0] <= bus_b.s_ena[s] ? mem_b[s][bus_b.s_addra[s*32+2 +: 4]] : 32'h0;
        rd_b[s][1] <= rd_b[s][0];
        rd_b[s][2] <= rd_b[s][1];
      end
    end
  end

  always_comb begin
    bus_a.s_douta = '0;
    bus_b.s_douta = '0;
    for (int s = 0; s < 4; s++) bus_a.s_douta[s*32 +: 32] = rd_a[s];
    for (int s = 0; s < 3; s++) bus_b.s_douta[s*32 +: 32] = rd_b[s][2];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.m_ena = '0; bus_a.m_wea = '0; bus_a.m_addra = '0; bus_a.m_dina = '0;
    bus_b.m_ena = '0; bus_b.m_wea = '0; bus_b.m_addra = '0; bus_b.m_dina = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rvalid_a", 64'(bus_a.m_rvalid), 64'h0);
    chk("rst_decerr_a", 64'(bus_a.m_decerr), 64'h0);
    chk("rst_douta_a",  bus_a.m_douta,       64'h0);
    chk("rst_rvalid_b", 64'(bus_b.m_rvalid), 64'h0);
    rst = 1'b0;
    tick();

    // Two masters, two different slaves, same cycle.
    bus_a.m_ena   = 2'b11;
    bus_a.m_addra = {32'h1000_0020, 32'h0000_0010};
    #2;
    chk("par_grant", 64'(bus_a.m_grant), 64'h3);
    chk("par_s_ena", 64'(bus_a.s_ena),   64'h3);
    tick();
    bus_a.m_ena = 2'b00;
    chk("par_rvalid", 64'(bus_a.m_rvalid), 64'h3);
    chk("par_douta",  bus_a.m_douta,       {32'h5001_0008, 32'h5000_0004});
    chk("par_decerr", 64'(bus_a.m_decerr), 64'h0);

    // Both masters hammer slave 2: grants alternate starting with M0.
    bus_a.m_ena   = 2'b11;
    bus_a.m_addra = {32'h2000_000C, 32'h2000_0008};
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rr_grant", 64'(bus_a.m_grant), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      chk("rr_rvalid", 64'(bus_a.m_rvalid), (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i % 2 == 0) chk("rr_douta_m0", 64'(bus_a.m_douta[31:0]),  64'h5002_0002);
      else            chk("rr_douta_m1", 64'(bus_a.m_douta[63:32]), 64'h5002_0003);
    end
    bus_a.m_ena = 2'b00;

    // Partial write from M1; idle slave 0 still shows M0's address.
    bus_a.m_ena   = 2'b10;
    bus_a.m_wea   = {4'b0011, 4'b0000};
    bus_a.m_addra = {32'h2000_0004, 32'h0000_0040};
    bus_a.m_dina  = {32'hDEAD_BEEF, 32'h0000_0000};
    #2;
    chk("wr_grant",   64'(bus_a.m_grant),         64'h2);
    chk("wr_s_ena",   64'(bus_a.s_ena),           64'h4);
    chk("wr_s_wea",   64'(bus_a.s_wea),           64'h0300);
    chk("wr_s_dina2", 64'(bus_a.s_dina[95:64]),   64'hDEAD_BEEF);
    chk("idle_addr0", 64'(bus_a.s_addra[31:0]),   64'h40);
    tick();
    bus_a.m_ena = 2'b00;
    bus_a.m_wea = '0;
    chk("wr_no_rvalid", 64'(bus_a.m_rvalid), 64'h0);
    bus_a.m_ena   = 2'b01;
    bus_a.m_addra = {32'h0000_0000, 32'h2000_0004};
    #2;
    chk("rdbk_grant", 64'(bus_a.m_grant), 64'h1);
    tick();
    bus_a.m_ena = 2'b00;
    chk("rdbk_rvalid", 64'(bus_a.m_rvalid),      64'h1);
    chk("rdbk_douta",  64'(bus_a.m_douta[31:0]), 64'h5002_BEEF);

    // Out-of-range select on the three-slave crossbar.
    bus_b.m_ena   = 2'b01;
    bus_b.m_addra = {32'h0000_0000, 32'h3000_0000};
    #2;
    chk("oor_grant", 64'(bus_b.m_grant), 64'h1);
`ifdef SRAM_XBAR_DECERR_EN
    chk("oor_s_ena", 64'(bus_b.s_ena), 64'h0);
`else
    chk("oor_s_ena", 64'(bus_b.s_ena), 64'h4);
`endif
    tick();
    bus_b.m_ena = 2'b00;
    tick();
    chk("oor_early", 64'(bus_b.m_rvalid), 64'h0);
    tick();
    chk("oor_rvalid", 64'(bus_b.m_rvalid), 64'h1);
`ifdef SRAM_XBAR_DECERR_EN
    chk("oor_decerr", 64'(bus_b.m_decerr),      64'h1);
    chk("oor_douta",  64'(bus_b.m_douta[31:0]), 64'h0);
`else
    chk("oor_decerr", 64'(bus_b.m_decerr),      64'h0);
    chk("oor_douta",  64'(bus_b.m_douta[31:0]), 64'h5002_0000);
`endif
    repeat (3) tick();

    // Four back-to-back reads at latency 3, then reset mid-flight.
    for (int i = 0; i < 4; i++) begin
      bus_b.m_ena   = 2'b01;
      bus_b.m_addra = {32'h0000_0000, 32'h1000_0000 + 32'(4 * i)};
      #2;
      chk("b2b_grant", 64'(bus_b.m_grant), 64'h1);
      if (i == 3) begin
        chk("b2b_rvalid", 64'(bus_b.m_rvalid),      64'h1);
        chk("b2b_douta",  64'(bus_b.m_douta[31:0]), 64'h5001_0000);
      end else begin
        chk("b2b_pre", 64'(bus_b.m_rvalid), 64'h0);
      end
      tick();
    end
    bus_b.m_ena = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_drop_b", 64'(bus_b.m_rvalid), 64'h0);
    chk("rst_drop_a", 64'(bus_a.m_rvalid), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rvalid", 64'(bus_b.m_rvalid), 64'h0);
    end

    // Pointers back at 0: M0 wins a contested slave on both crossbars.
    bus_b.m_ena   = 2'b11;
    bus_b.m_addra = {32'h1000_0004, 32'h1000_0008};
    bus_a.m_ena   = 2'b11;
    bus_a.m_addra = {32'h0000_0004, 32'h0000_0008};
    #2;
    chk("ptr_rst_b", 64'(bus_b.m_grant), 64'h1);
    chk("ptr_rst_a", 64'(bus_a.m_grant), 64'h1);
    tick();
    bus_a.m_ena = 2'b00;
    bus_b.m_ena = 2'b00;
    chk("ptr_rd_a", 64'(bus_a.m_douta[31:0]), 64'h5000_0002);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_xbar_mn.md
# sram_xbar_mn

Parametrised M-master × N-slave SRAM-port crossbar; successor to the single-master two-slave SRAM mux. Address-decodes each master request to one of N block-RAM slaves and arbitrates round-robin per slave, so independent masters reach different slaves in the same cycle. Read data returns to the issuing master after a fixed slave read latency. Sits between core fetch/LSU SRAM ports and on-chip BRAM banks.

## Interface
- `LEN_ADDR`, 32, address width
- `LEN_DATA`, 32, data width (multiple of 8)
- `NUM_MASTER`, 2, master ports (≥1)
- `NUM_SLAVE`, 4, slave ports (≥2)
- `READ_LAT`, 1, slave read latency in cycles (≥1)
- `SEL_LSB`, 28, LSB of slave-select field; field width `SW = $clog2(NUM_SLAVE)`
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: clock
- `rst` in 1: async active-high reset
- `m_ena` in NUM_MASTER: request per master
- `m_wea` in NUM_MASTER*LEN_DATA/8: byte write enables; all zero = read
- `m_addra` in NUM_MASTER*LEN_ADDR: request address
- `m_dina` in NUM_MASTER*LEN_DATA: write data
- `m_grant` out NUM_MASTER: request accepted this cycle
- `m_rvalid` out NUM_MASTER: `m_douta` valid
- `m_douta` out NUM_MASTER*LEN_DATA: read data
- `m_decerr` out NUM_MASTER: decode error, qualified by `m_rvalid`
- `s_ena` out NUM_SLAVE: slave enable
- `s_wea` out NUM_SLAVE*LEN_DATA/8: slave byte enables
- `s_addra` out NUM_SLAVE*LEN_ADDR: full master address, unmodified
- `s_dina` out NUM_SLAVE*LEN_DATA: write data
- `s_douta` in NUM_SLAVE*LEN_DATA: slave read data, READ_LAT after enable

## Operation
- Target slave = `m_addra[SEL_LSB +: SW]`; index ≥ NUM_SLAVE is out of range.
- Each slave has a round-robin arbiter over the masters targeting it. Priority pointer resets to 0 (master 0 highest). After a grant to master k, the pointer becomes (k+1) mod NUM_MASTER. Without a grant, the pointer holds.
- Winner drives `s_ena=1`, `s_wea`, `s_addra`, `s_dina`. Idle slave: `s_ena=0`, `s_wea=0`, addr/data driven from master 0.
- Losing master: `m_grant=0`. It must hold `m_ena`/addr/data/wea stable until granted. A request that is not granted has no side effects.
- Each master has a response pipe of READ_LAT stages. Each stage holds {valid, slave index, decerr}. A granted read (`m_wea==0`) enters a valid entry; a granted write enters an invalid entry.
- Pipe output: `m_rvalid` = entry valid; `m_douta` = `s_douta` of the recorded slave (0 on decerr); `m_decerr` = recorded flag.
- Masters may issue back-to-back every cycle. Throughput is 1 access/master/cycle when there is no slave conflict.

## Timing
- Request accept, arbitration and slave drive are combinational within cycle T.
- `m_rvalid` and `m_douta` are asserted in cycle T+READ_LAT. `m_douta` is a combinational mux of registered tag and `s_douta`.
- A same-cycle read and write to the same slave by different masters is arbitrated like any other conflict.
- Reset values: all pipe entries invalid, so `m_rvalid=0` and `m_decerr=0`. `m_douta` is 0 while invalid. All pointers are 0.
- Reset asserted mid-operation drops in-flight responses. No `m_rvalid` follows for them.

## Configuration
- `SRAM_XBAR_DECERR_EN` defined: an out-of-range request is granted immediately without enabling any slave and without arbitration. A read returns `m_rvalid=1`, `m_decerr=1`, `m_douta=0` at T+READ_LAT. A write is silently dropped after grant.
- Undefined: an out-of-range index maps to slave NUM_SLAVE-1, and `m_decerr` is tied 0.
- Power-of-two NUM_SLAVE never produces out-of-range.

## Structure
- Package `sram_xbar_pkg`: response tag typedef {valid, slave idx, decerr}, width helper functions.
- Sub-module `sram_xbar_rr_arb` (NUM_MASTER requesters, one-hot grant, pointer register). Instantiate one per slave.

## Test plan
- M0 reads 0x0000_0010 (slave 0), M1 reads 0x1000_0020 (slave 1) in the same cycle → both granted. With READ_LAT=1, both `m_rvalid` assert the next cycle with their own slave data.
- M0 and M1 request slave 2 continuously → grants alternate M0, M1, M0…. No request is lost, and each read returns the correct data.
- M1 writes `m_wea=4'b0011` data 0xDEAD_BEEF to 0x2000_0004 while granted → only `s_ena[2]` and `s_wea[2]=0011`. No `m_rvalid`. A later read returns 0x????_BEEF per slave contents.
- NUM_SLAVE=3, macro defined: read 0x3000_0000 → granted in the same cycle, no `s_ena`, `m_decerr=1`, `m_douta=0` at T+READ_LAT. Macro undefined: the same read hits slave 2.
- READ_LAT=3, 4 back-to-back reads → `m_rvalid` in cycles T+3…T+6 in order. Assert `rst` at T+4 → no further `m_rvalid`, and pointers return to 0.
